instr_decode: RTL
=================

# instr_decode

Instruction-decode stage of the five-stage pipeline, directly downstream of instruction fetch. Consumes the IF/ID instruction and next-PC, decodes the opcode into pipelined control fields, reads two operands from a 32x32 register file, sign-extends the immediate, and registers everything into the ID/EX pipeline register. Also accepts the write-back port from the MEM/WB stage.

## Interface
- No parameters; widths fixed at 32-bit datapath, 5-bit register index.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; clears register file and all ID/EX outputs
- if_id_ir  in  32  instruction from IF/ID register
- if_id_npc  in  32  PC+4 from IF/ID register
- wb_regwrite  in  1  write-back enable from MEM/WB
- wb_write_reg  in  5  write-back destination index
- wb_write_data  in  32  write-back data
- id_ex_wb  out  2  {RegWrite, MemtoReg}
- id_ex_m  out  3  {Branch, MemRead, MemWrite}
- id_ex_ex  out  4  {RegDst, ALUOp[1:0], ALUSrc}
- id_ex_npc  out  32  registered if_id_npc
- id_ex_rd1  out  32  register[rs]
- id_ex_rd2  out  32  register[rt]
- id_ex_imm  out  32  sign-extended instr[15:0]
- id_ex_rt  out  5  instr[20:16]
- id_ex_rd  out  5  instr[15:11]

## Operation
- Opcode = instr[31:26]; rs = [25:21], rt = [20:16], rd = [15:11].
- Control decode: R-type (0x00): RegDst=1, ALUOp=10, ALUSrc=0, RegWrite=1, others 0. lw (0x23): ALUSrc=1, MemRead=1, RegWrite=1, MemtoReg=1, ALUOp=00. sw (0x2B): ALUSrc=1, MemWrite=1, ALUOp=00. beq (0x04): Branch=1, ALUOp=01. Any other opcode: all control bits 0 (bubble); datapath fields still registered.
- Instruction 0x00000000 decodes as R-type sll $0 — RegWrite=1 to $0, harmless since $0 is never written.
- Register file: 32 entries; $0 reads 0 always; writes to index 0 ignored.
- Write on rising clk when wb_regwrite=1 and wb_write_reg≠0.
- Write-through: if wb_regwrite=1, wb_write_reg≠0 and equals rs (or rt) in the same cycle, the read port returns wb_write_data, not the stale entry.
- Sign extension: imm = {{16{instr[15]}}, instr[15:0]}.
- No stall/flush inputs in this revision; every cycle advances.

## Timing
- Latency 1 cycle: inputs sampled at rising edge N appear on id_ex_* after edge N.
- Register-file write and ID/EX capture happen on the same edge; bypass guarantees the captured operand is the newly written value.
- Reset (reset=0) asynchronously forces every output and every register-file entry to 0, independent of clk; takes effect mid-cycle. First capture occurs on the first rising edge after reset deasserts.
- Write-back asserted during reset is discarded.
- Reads are combinational from registered state plus bypass; no combinational path from inputs to outputs.

## Structure
- Shared package: opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ), ALUOp encodings, control-field widths and bit positions.
- One sub-module: register_file (two async read ports with write-through bypass, one sync write port, async active-low clear). Control decode and sign extension stay inline.

## Test plan
- Reset: hold reset=0 with random inputs -> all id_ex_* = 0; after release, reading $1..$31 yields 0.
- Write then read: write $5=0xDEADBEEF, next cycle decode add $3,$5,$0 (0x00A01820) -> id_ex_rd1=0xDEADBEEF, rd2=0, id_ex_ex=4'b1100, id_ex_wb=2'b10, id_ex_rd=3.
- Same-cycle bypass: wb write $8=0x12345678 while if_id_ir=lw $9,-4($8) (0x8D09FFFC) -> id_ex_rd1=0x12345678, id_ex_imm=0xFFFFFFFC, id_ex_m=3'b010, id_ex_wb=2'b11.
- $0 protection: write $0=0xFFFFFFFF, then decode with rs=0 -> id_ex_rd1=0.
- Branch/store/unknown: beq (0x11090003) -> id_ex_m=3'b100, ALUOp=01, imm=3; sw (0xAD090010) -> MemWrite=1, RegWrite=0; opcode 0x3F -> all control 0.
- Async reset mid-stream: assert reset=0 between edges after loading registers -> outputs 0 immediately; post-release reads return 0.

Source files
------------

// File: rtl/instr_decode_pkg.sv
// Shared definitions for the instruction-decode stage.
// Holds opcode constants, ALUOp encodings, control-field widths and bit
// positions, the packed control bundle, and the opcode-to-control decoder.
package instr_decode_pkg;

    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 5;
    localparam int NUM_REGS  = 32;

    // Opcodes understood by the decoder (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    // ALUOp encodings handed to the EX stage
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Control-field widths
    localparam int WB_W = 2;
    localparam int M_W  = 3;
    localparam int EX_W = 4;

    // WB field: {RegWrite, MemtoReg}
    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;

    // M field: {Branch, MemRead, MemWrite}
    localparam int M_BRANCH   = 2;
    localparam int M_MEMREAD  = 1;
    localparam int M_MEMWRITE = 0;

    // EX field: {RegDst, ALUOp[1:0], ALUSrc}
    localparam int EX_REGDST   = 3;
    localparam int EX_ALUOP_HI = 2;
    localparam int EX_ALUOP_LO = 1;
    localparam int EX_ALUSRC   = 0;

    typedef struct packed {
        logic [WB_W-1:0] wb;
        logic [M_W-1:0]  m;
        logic [EX_W-1:0] ex;
    } ctrl_t;

    // Unrecognised opcodes fall through as an all-zero bubble.
    function automatic ctrl_t decode_ctrl(input logic [5:0] opcode);
        ctrl_t c;
        c = '0;
        case (opcode)
            OP_RTYPE: begin
                c.ex[EX_REGDST]                = 1'b1;
                c.ex[EX_ALUOP_HI:EX_ALUOP_LO]  = ALUOP_FUNCT;
                c.wb[WB_REGWRITE]              = 1'b1;
            end
            OP_LW: begin
                c.ex[EX_ALUSRC]                = 1'b1;
                c.ex[EX_ALUOP_HI:EX_ALUOP_LO]  = ALUOP_ADD;
                c.m[M_MEMREAD]                 = 1'b1;
                c.wb[WB_REGWRITE]              = 1'b1;
                c.wb[WB_MEMTOREG]              = 1'b1;
            end
            OP_SW: begin
                c.ex[EX_ALUSRC]                = 1'b1;
                c.ex[EX_ALUOP_HI:EX_ALUOP_LO]  = ALUOP_ADD;
                c.m[M_MEMWRITE]                = 1'b1;
            end
            OP_BEQ: begin
                c.ex[EX_ALUOP_HI:EX_ALUOP_LO]  = ALUOP_SUB;
                c.m[M_BRANCH]                  = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/instr_decode_register_file.sv
// 32x32 register file for the decode stage.
// Ports:
//   clk, reset        clock, asynchronous active-low clear of all entries
//   read_reg1/2       read indices (combinational read ports)
//   read_data1/2      read data; $0 reads 0, same-cycle write is bypassed
//   write_en          write enable (sampled on rising clk)
//   write_reg         write index; writes to $0 are dropped
//   write_data        write data
module register_file
    import instr_decode_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [REG_IDX_W-1:0] read_reg1,
    input  logic [REG_IDX_W-1:0] read_reg2,
    output logic [XLEN-1:0]      read_data1,
    output logic [XLEN-1:0]      read_data2,
    input  logic                 write_en,
    input  logic [REG_IDX_W-1:0] write_reg,
    input  logic [XLEN-1:0]      write_data
);

    // $0 has no storage: it is hardwired to zero on the read side.
    logic [XLEN-1:0] regs [1:NUM_REGS-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (write_en && (write_reg != '0)) begin
            regs[write_reg] <= write_data;
        end
    end

    // Write-through: the consumer captures on the same edge as the write,
    // so it must see the incoming value rather than the stale entry.
    always_comb begin
        read_data1 = '0;
        if (read_reg1 != '0) begin
            if (write_en && (write_reg == read_reg1)) begin
                read_data1 = write_data;
            end else begin
                read_data1 = regs[read_reg1];
            end
        end
    end

    always_comb begin
        read_data2 = '0;
        if (read_reg2 != '0) begin
            if (write_en && (write_reg == read_reg2)) begin
                read_data2 = write_data;
            end else begin
                read_data2 = regs[read_reg2];
            end
        end
    end

endmodule

// File: rtl/instr_decode.sv
// Instruction-decode pipeline stage with ID/EX pipeline register.
// Decodes the IF/ID instruction into WB/M/EX control fields, reads rs/rt
// from the register file (with write-back bypass), sign-extends the
// immediate and registers everything into ID/EX.
// Ports:
//   clk, reset                  clock, asynchronous active-low reset
//   if_id_ir, if_id_npc         instruction and PC+4 from IF/ID
//   wb_regwrite, wb_write_reg,
//   wb_write_data               write-back port from MEM/WB
//   id_ex_wb/m/ex               registered control fields
//   id_ex_npc                   registered PC+4
//   id_ex_rd1, id_ex_rd2        registered operands register[rs], register[rt]
//   id_ex_imm                   registered sign-extended immediate
//   id_ex_rt, id_ex_rd          registered destination candidates
module instr_decode
    import instr_decode_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [XLEN-1:0]      if_id_ir,
    input  logic [XLEN-1:0]      if_id_npc,
    input  logic                 wb_regwrite,
    input  logic [REG_IDX_W-1:0] wb_write_reg,
    input  logic [XLEN-1:0]      wb_write_data,
    output logic [WB_W-1:0]      id_ex_wb,
    output logic [M_W-1:0]       id_ex_m,
    output logic [EX_W-1:0]      id_ex_ex,
    output logic [XLEN-1:0]      id_ex_npc,
    output logic [XLEN-1:0]      id_ex_rd1,
    output logic [XLEN-1:0]      id_ex_rd2,
    output logic [XLEN-1:0]      id_ex_imm,
    output logic [REG_IDX_W-1:0] id_ex_rt,
    output logic [REG_IDX_W-1:0] id_ex_rd
);

    function automatic logic signed [XLEN-1:0] sign_ext16(input logic signed [15:0] v);
        return {{(XLEN-16){v[15]}}, v};
    endfunction

    logic [5:0]           opcode_p0;
    logic [REG_IDX_W-1:0] rs_p0;
    logic [REG_IDX_W-1:0] rt_p0;
    logic [REG_IDX_W-1:0] rd_p0;
    logic [XLEN-1:0]      imm_p0;
    logic [XLEN-1:0]      rd1_p0;
    logic [XLEN-1:0]      rd2_p0;
    ctrl_t                ctrl_p0;

    assign opcode_p0 = if_id_ir[31:26];
    assign rs_p0     = if_id_ir[25:21];
    assign rt_p0     = if_id_ir[20:16];
    assign rd_p0     = if_id_ir[15:11];
    assign imm_p0    = sign_ext16(if_id_ir[15:0]);
    assign ctrl_p0   = decode_ctrl(opcode_p0);

    register_file u_register_file (
        .clk        (clk),
        .reset      (reset),
        .read_reg1  (rs_p0),
        .read_reg2  (rt_p0),
        .read_data1 (rd1_p0),
        .read_data2 (rd2_p0),
        .write_en   (wb_regwrite),
        .write_reg  (wb_write_reg),
        .write_data (wb_write_data)
    );

    // ---- ID/EX pipeline register boundary ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            id_ex_wb  <= '0;
            id_ex_m   <= '0;
            id_ex_ex  <= '0;
            id_ex_npc <= '0;
            id_ex_rd1 <= '0;
            id_ex_rd2 <= '0;
            id_ex_imm <= '0;
            id_ex_rt  <= '0;
            id_ex_rd  <= '0;
        end else begin
            id_ex_wb  <= ctrl_p0.wb;
            id_ex_m   <= ctrl_p0.m;
            id_ex_ex  <= ctrl_p0.ex;
            id_ex_npc <= if_id_npc;
            id_ex_rd1 <= rd1_p0;
            id_ex_rd2 <= rd2_p0;
            id_ex_imm <= imm_p0;
            id_ex_rt  <= rt_p0;
            id_ex_rd  <= rd_p0;
        end
    end

endmodule
